// File: rtl/interleaver_seq.sv
// Sequential sweep interleaver: steps through one junction of fo*p/z cycles and streams
// z left-neuron addresses per cycle. Optional seed readback port under INTLV_SEED_READBACK_EN.
module interleaver_seq #(
  parameter int fo = 2,
  parameter int p  = 32,
  parameter int z  = 8,
  parameter int unsigned SEED_INIT [fo*z] = '{1, 3, 2, 0, 0, 2, 1, 3, 2, 0, 3, 1, 3, 1, 0, 2},
  localparam int PZ   = p / z,
  localparam int FOZ  = fo * z,
  localparam int NCYC = fo * PZ,
  localparam int SW   = (PZ   > 1) ? $clog2(PZ)   : 1,
  localparam int SAW  = (FOZ  > 1) ? $clog2(FOZ)  : 1,
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1,
  localparam int LP   = (p    > 1) ? $clog2(p)    : 1,
  localparam int PKW  = LP * z
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  input  logic           seed_we,
  input  logic [SAW-1:0] seed_waddr,
  input  logic [SW-1:0]  seed_wdata,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  out_cycle,
  output logic           out_last,
  output logic [PKW-1:0] memory_index_package,
  output logic           done
`ifdef INTLV_SEED_READBACK_EN
  ,
  input  logic [SAW-1:0] seed_raddr,
  output logic [SW-1:0]  seed_rdata
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q;
  logic           busy_q;
  logic           valid_q;
  logic [CW-1:0]  cyc_q;
  logic           last_q;
  logic [PKW-1:0] pkg_q;
  logic           done_q;
  logic [SW-1:0]  seed_q   [FOZ];
  logic [SW-1:0]  seed_eff [FOZ];
  logic [CW-1:0]  cyc_d;
  logic [PKW-1:0] pkg_d;
  logic           xfer;

  // Lane j of cycle c: seed of sweep c/PZ rotated by c mod PZ, then interleaved with lane j.
  function automatic logic [PKW-1:0] addr_pkg(input logic [CW-1:0] c,
                                               input logic [SW-1:0] tbl [FOZ]);
    logic [PKW-1:0] pk;
    int s;
    int i;
    int a;
    pk = '0;
    s  = int'(c) / PZ;
    i  = int'(c) % PZ;
    for (int j = 0; j < z; j++) begin
      a = ((int'(tbl[s*z + j]) + i) % PZ) * z + j;
      pk[j*LP +: LP] = LP'(a);
    end
    return pk;
  endfunction

  // Writes land only while idle; forwarding lets a same-cycle start see the new seed.
  always_comb begin
    seed_eff = seed_q;
    if (seed_we && !busy_q && (int'(seed_waddr) < FOZ))
      seed_eff[seed_waddr] = seed_wdata;
  end

  always_comb begin
    cyc_d = '0;
    if (state_q == RUN)
      cyc_d = cyc_q + CW'(1);
  end

  assign pkg_d = addr_pkg(cyc_d, seed_eff);
  assign xfer  = valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      cyc_q   <= '0;
      last_q  <= 1'b0;
      pkg_q   <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < FOZ; k++)
        seed_q[k] <= SW'(SEED_INIT[k]);
    end else begin
      seed_q <= seed_eff;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            valid_q <= 1'b1;
            cyc_q   <= cyc_d;
            last_q  <= (NCYC == 1);
            pkg_q   <= pkg_d;
          end
        end
        RUN: begin
          if (xfer) begin
            if (last_q) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cyc_q  <= cyc_d;
              last_q <= (cyc_d == CW'(NCYC - 1));
              pkg_q  <= pkg_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef INTLV_SEED_READBACK_EN
  logic [SW-1:0] seed_rdata_q;

  // Reads the pre-write table, so a colliding write is not visible until the next read.
  always_ff @(posedge clk) begin
    if (reset)
      seed_rdata_q <= '0;
    else
      seed_rdata_q <= seed_q[seed_raddr];
  end

  assign seed_rdata = seed_rdata_q;
`endif

  assign busy                 = busy_q;
  assign out_valid            = valid_q;
  assign out_cycle            = cyc_q;
  assign out_last             = last_q;
  assign memory_index_package = pkg_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_interleaver_seq.sv
// Randomised self-checking bench for interleaver_seq against a per-cycle address model.
module tb_interleaver_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        seed_we;
  logic [3:0]  seed_waddr;
  logic [1:0]  seed_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_cycle;
  logic        out_last;
  logic [39:0] memory_index_package;
  logic        done;
`ifdef INTLV_SEED_READBACK_EN
  logic [3:0]  seed_raddr;
  logic [1:0]  seed_rdata;
`endif

  int checks   = 0;
  int failures = 0;
  int mseed [16];
  logic [39:0] cap [8];
  int lat;

  localparam int DEF_SEED [16] = '{1, 3, 2, 0, 0, 2, 1, 3, 2, 0, 3, 1, 3, 1, 0, 2};

  interleaver_seq dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .busy                 (busy),
    .seed_we              (seed_we),
    .seed_waddr           (seed_waddr),
    .seed_wdata           (seed_wdata),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_cycle            (out_cycle),
    .out_last             (out_last),
    .memory_index_package (memory_index_package),
    .done                 (done)
`ifdef INTLV_SEED_READBACK_EN
    ,
    .seed_raddr           (seed_raddr),
    .seed_rdata           (seed_rdata)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Four cycles per sweep, eight lanes: rotate the sweep seed by the in-sweep index.
  function automatic logic [39:0] exp_pkg(input int c);
    logic [39:0] r;
    int a;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      a = ((mseed[(c / 4) * 8 + j] + (c % 4)) % 4) * 8 + j;
      r[j*5 +: 5] = a[4:0];
    end
    return r;
  endfunction

  task automatic idle_write(input int a, input int d);
    seed_we    = 1'b1;
    seed_waddr = a[3:0];
    seed_wdata = d[1:0];
    mseed[a]   = d % 4;
    tick();
    seed_we = 1'b0;
  endtask

  // mode 0: ready held; 1: random ready, stray starts and writes; 2: 3-cycle stall at cycle 2;
  // 3: ready held with writes to entry 1 throughout. ws_addr >= 0 writes alongside start.
  task automatic run_junction(input int mode, input int ws_addr, input int ws_data);
    int phase;
    int c_exp;
    int holds;
    bit fin;
    phase = 1;
    c_exp = 0;
    holds = 0;
    lat   = 0;
    fin   = 1'b0;
    start = 1'b1;
    if (ws_addr >= 0) begin
      seed_we    = 1'b1;
      seed_waddr = ws_addr[3:0];
      seed_wdata = ws_data[1:0];
      mseed[ws_addr] = ws_data % 4;
    end
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    tick();
    for (int cyc = 1; cyc < 200 && !fin; cyc++) begin
      chk("valid", out_valid, phase == 1);
      chk("busy", busy, 1'b1);
      chk("done", done, phase == 2);
      if (done && lat == 0) lat = cyc;
      if (phase == 1) begin
        chk("cycle", out_cycle, c_exp);
        chk("last", out_last, c_exp == 7);
        chk("pkg", memory_index_package, exp_pkg(c_exp));
      end
      case (mode)
        1: begin
          out_ready  = 1'($urandom_range(0, 1));
          start      = 1'($urandom_range(0, 1));
          seed_we    = 1'($urandom_range(0, 1));
          seed_waddr = 4'($urandom_range(0, 15));
          seed_wdata = 2'($urandom_range(0, 3));
        end
        2: begin
          start   = 1'b0;
          seed_we = 1'b0;
          if (c_exp == 2 && holds < 3) begin
            out_ready = 1'b0;
            holds++;
          end else begin
            out_ready = 1'b1;
          end
        end
        3: begin
          start      = 1'b0;
          out_ready  = 1'b1;
          seed_we    = 1'b1;
          seed_waddr = 4'd1;
          seed_wdata = 2'd0;
        end
        default: begin
          start     = 1'b0;
          seed_we   = 1'b0;
          out_ready = 1'b1;
        end
      endcase
      if (phase == 2) begin
        start = 1'b1;
        fin   = 1'b1;
      end else if (out_valid && out_ready) begin
        cap[c_exp] = memory_index_package;
        if (c_exp == 7) phase = 2;
        else c_exp++;
      end
      tick();
    end
    if (!fin) begin
      failures++;
      $error("FAIL timeout: observed=%0d expected=%0d", phase, 3);
    end
    start   = 1'b0;
    seed_we = 1'b0;
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", out_valid, 1'b0);
    chk("idle_done", done, 1'b0);
    tick();
    chk("no_restart", busy, 1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    seed_we    = 1'b0;
    seed_waddr = '0;
    seed_wdata = '0;
    out_ready  = 1'b0;
`ifdef INTLV_SEED_READBACK_EN
    seed_raddr = '0;
`endif
    for (int k = 0; k < 16; k++) mseed[k] = DEF_SEED[k];
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_cycle", out_cycle, 3'd0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_pkg", memory_index_package, 40'd0);
    chk("rst_done", done, 1'b0);
    tick();

    run_junction(0, -1, 0);
    chk("latency", lat, 9);
    chk("cyc0_default", cap[0], {5'd31, 5'd14, 5'd21, 5'd4, 5'd3, 5'd18, 5'd25, 5'd8});
    chk("cyc4_default", cap[4], {5'd23, 5'd6, 5'd13, 5'd28, 5'd11, 5'd26, 5'd1, 5'd16});

    run_junction(2, -1, 0);

    idle_write(0, 2);
    run_junction(0, -1, 0);
    chk("wr_c0_l0", cap[0][4:0], 5'd16);
    chk("wr_c1_l0", cap[1][4:0], 5'd24);

    run_junction(3, -1, 0);
    run_junction(0, -1, 0);
    chk("runwr_c0_l1", cap[0][9:5], 5'd25);

    run_junction(0, 2, 3);
    chk("startwr_c0_l2", cap[0][14:10], 5'd26);

    // Abort a run at cycle 5 with reset; seeds must revert to defaults.
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && out_cycle != 3'd5; k++) tick();
    chk("at_cycle5", out_cycle, 3'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) mseed[k] = DEF_SEED[k];
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_cycle", out_cycle, 3'd0);
    chk("abort_pkg", memory_index_package, 40'd0);
    chk("abort_done", done, 1'b0);
    tick();
    chk("abort_nodone", done, 1'b0);
    run_junction(0, -1, 0);
    chk("replay_c0", cap[0], {5'd31, 5'd14, 5'd21, 5'd4, 5'd3, 5'd18, 5'd25, 5'd8});

`ifdef INTLV_SEED_READBACK_EN
    idle_write(9, 3);
    seed_raddr = 4'd9;
    tick();
    chk("rd_9", seed_rdata, 2'd3);
    seed_raddr = 4'd15;
    tick();
    chk("rd_15", seed_rdata, 2'd2);
`endif

    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 3; w++)
        idle_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      run_junction(1, -1, 0);
    end
    run_junction(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interleaver_seq.md
Name: interleaver_seq

Overview:
Sequential, runtime-programmable successor to the combinational sweep interleaver. It steps the cycle index internally through one junction of fo*p/z cycles and emits z left-neuron memory addresses per cycle over a valid/ready stream. Sweep-start seeds sit in a writable register table rather than a fixed parameter. It sits between the junction controller and the left-side activation/delta memory banks.

Parameters:
fo, 2, fan-out; number of sweeps per junction
p, 32, left-layer neuron count; power of 2, p >= z
z, 8, addresses generated per cycle; power of 2
SEED_INIT, {1,3,2,0,0,2,1,3,2,0,3,1,3,1,0,2}, reset contents of the seed table; fo*z entries of log2(p/z) bits; first listed entry is entry 0

Ports:
clk  in  1  clock; all logic is rising-edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request to run one junction
busy  out  1  high from the start acceptance until the done cycle, inclusive
seed_we  in  1  seed-table write strobe
seed_waddr  in  log2(fo*z)  seed entry index, sweep*z + lane
seed_wdata  in  log2(p/z)  seed value
out_valid  out  1  address package valid
out_ready  in  1  consumer accepts the package
out_cycle  out  log2(fo*p/z)  cycle index of the current package
out_last  out  1  current package is cycle fo*p/z-1
memory_index_package  out  log2(p)*z  lane j at bits [log2(p)*(j+1)-1 : log2(p)*j]
done  out  1  one-cycle pulse after the last package is accepted

Behaviour:
- Reset values: busy=0, out_valid=0, out_cycle=0, out_last=0, memory_index_package=0, done=0, state=IDLE, seed table=SEED_INIT.
- States:
  - IDLE: start=1 -> RUN. Next cycle: out_valid=1, out_cycle=0, package for cycle 0. Latency is 1 clock.
  - RUN: a beat transfers when out_valid && out_ready. On transfer of a non-last beat, the next edge loads cycle c+1 and keeps out_valid=1, so back-to-back transfers run one per clock. On transfer of the last beat -> DONE and out_valid=0.
  - DONE: lasts one cycle with done=1 and busy=1, then -> IDLE.
- Backpressure: while out_valid && !out_ready, out_cycle, out_last and memory_index_package hold stable.
- Address rule for cycle c and lane j:
  - S = c >> log2(p/z) (sweep number)
  - i = c mod (p/z)
  - addr_j = ((seed[S*z+j] + i) mod (p/z))*z + j
  - The mod (p/z) is realised by truncation to log2(p/z) bits.
  - When fo=1, S=0.
- Registered output: addresses are computed from the next cycle index and loaded into the output register. There is no combinational path from out_ready to the package.
- Seed writes:
  - Accepted only when busy=0. The written entry is visible to the next start.
  - seed_we while busy=1 is ignored and the table is unchanged.
  - A write in the same cycle as an accepted start is performed, and the run uses the new value.
- start while busy=1 is ignored.
- Counter wrap: out_cycle never wraps within a run. The run ends at fo*p/z-1.
- Reset mid-run: the next edge returns all outputs to reset values, aborts the run with no done pulse, and restores SEED_INIT.

Optional Feature:
INTLV_SEED_READBACK_EN.
- Defined: adds ports seed_raddr (in, log2(fo*z)) and seed_rdata (out, log2(p/z)). seed_rdata is registered and returns seed[seed_raddr] one cycle later. seed_rdata resets to 0. A read of an entry being written in the same cycle returns the old value.
- Undefined: neither port exists and the table is write-only.

Test Plan:
- Defaults, reset then start, out_ready=1 held: cycle 0 package lanes 0..7 = 8,25,18,3,4,21,14,31; cycle 4 = 16,1,26,11,28,13,6,23; out_last=1 only at out_cycle=7; done pulses exactly once, 9 cycles after start.
- Backpressure: drop out_ready for 3 cycles at out_cycle=2 -> package and out_cycle hold; the sequence resumes with no skipped or repeated cycle; 8 transfers total.
- Seed write: in IDLE write seed_waddr=0, seed_wdata=2, then start -> cycle 0 lane 0 = 16 and cycle 1 lane 0 = 24; a write to entry 1 during RUN leaves cycle 0 lane 1 = 25 on the next run.
- Reset at out_cycle=5 -> next cycle out_valid=0, busy=0, no done pulse; a new start replays cycle 0 = 8,25,...,31 with the default seeds.
- start pulsed during RUN and in the DONE cycle -> ignored; exactly one 8-beat run and one done pulse.
- With INTLV_SEED_READBACK_EN defined: write 3 to entry 9, read address 9 -> seed_rdata=3 one cycle later; read entry 15 -> 2.
